// File: rtl/mul_share_arb.sv
// mul_share_arb: one 8x8 unsigned multiplier shared by NREQ requesters.
// Round-robin arbitration feeds a two-stage pipeline: an issue register,
// the carry-save multiplier array, and a response register with
// valid/ready backpressure and requester-ID return.
module mul_share_arb #(
    parameter int WIDTH = 8,
    parameter int NREQ  = 4,
    parameter int IDW   = 2,
    parameter int CNTW  = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NREQ-1:0]       req_valid,
    output logic [NREQ-1:0]       req_ready,
    input  logic [NREQ*WIDTH-1:0] req_x,
    input  logic [NREQ*WIDTH-1:0] req_y,
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic [IDW-1:0]        resp_id,
    output logic [2*WIDTH-1:0]    resp_p,
    output logic                  busy,
    output logic [CNTW-1:0]       op_cnt
);

    localparam int PW = 2 * WIDTH;

    // Partial-product array reduced with 3:2 carry-save compressors, then
    // one final carry-propagate add. Carries past the top bit are dropped;
    // the true product always fits in PW bits, so the result is exact.
    function automatic logic [PW-1:0] wallace_mul(input logic [WIDTH-1:0] a,
                                                  input logic [WIDTH-1:0] b);
        logic [PW-1:0] s;
        logic [PW-1:0] c;
        logic [PW-1:0] pp;
        logic [PW-1:0] t;
        s = b[0] ? PW'(a) : '0;
        c = b[1] ? (PW'(a) << 1) : '0;
        for (int i = 2; i < WIDTH; i++) begin
            pp = b[i] ? (PW'(a) << i) : '0;
            t  = s ^ c ^ pp;
            c  = ((s & c) | (s & pp) | (c & pp)) << 1;
            s  = t;
        end
        return s + c;
    endfunction

    // Control state (reset)
    logic [IDW-1:0]  rr_ptr_q, rr_ptr_d;
    logic            s1_vld_q, s1_vld_d;
    logic            resp_valid_q, resp_valid_d;
    logic [IDW-1:0]  resp_id_q, resp_id_d;
    logic [PW-1:0]   resp_p_q, resp_p_d;
    logic [CNTW-1:0] op_cnt_q, op_cnt_d;
    // Issue-stage payload (no reset; qualified by s1_vld_q)
    logic [IDW-1:0]   s1_id_q, s1_id_d;
    logic [WIDTH-1:0] s1_x_q, s1_x_d;
    logic [WIDTH-1:0] s1_y_q, s1_y_d;

    logic             s1_adv, s2_adv, grant;
    logic             gnt_vld;
    logic [IDW-1:0]   gnt_id;
    logic [IDW:0]     scan;
    logic [WIDTH-1:0] gnt_x, gnt_y;

    assign s2_adv = !resp_valid_q || resp_ready;
    assign s1_adv = !s1_vld_q || s2_adv;
    assign grant  = gnt_vld && s1_adv;

    // Round-robin scan from rr_ptr upward; first valid requester wins.
    always_comb begin
        gnt_vld = 1'b0;
        gnt_id  = '0;
        scan    = '0;
        for (int k = 0; k < NREQ; k++) begin
            scan = {1'b0, rr_ptr_q} + (IDW+1)'(k);
            if (scan >= (IDW+1)'(NREQ)) begin
                scan = scan - (IDW+1)'(NREQ);
            end
            if (!gnt_vld && req_valid[scan[IDW-1:0]]) begin
                gnt_vld = 1'b1;
                gnt_id  = scan[IDW-1:0];
            end
        end
    end

    // Operand select and one-hot ready for the winning requester.
    always_comb begin
        gnt_x     = '0;
        gnt_y     = '0;
        req_ready = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (gnt_id == IDW'(k)) begin
                gnt_x = req_x[k*WIDTH +: WIDTH];
                gnt_y = req_y[k*WIDTH +: WIDTH];
            end
            req_ready[k] = rst_n && grant && (gnt_id == IDW'(k));
        end
    end

    // Next-state for pointer, both pipeline stages and the op counter.
    always_comb begin
        rr_ptr_d     = rr_ptr_q;
        s1_vld_d     = s1_vld_q;
        s1_id_d      = s1_id_q;
        s1_x_d       = s1_x_q;
        s1_y_d       = s1_y_q;
        resp_valid_d = resp_valid_q;
        resp_id_d    = resp_id_q;
        resp_p_d     = resp_p_q;
        op_cnt_d     = op_cnt_q;

        if (grant) begin
            rr_ptr_d = (gnt_id == IDW'(NREQ-1)) ? '0 : gnt_id + 1'b1;
        end
        if (s1_adv) begin
            s1_vld_d = gnt_vld;
            if (gnt_vld) begin
                s1_id_d = gnt_id;
                s1_x_d  = gnt_x;
                s1_y_d  = gnt_y;
            end
        end
        if (s2_adv) begin
            resp_valid_d = s1_vld_q;
            resp_id_d    = s1_id_q;
            resp_p_d     = wallace_mul(s1_x_q, s1_y_q);
        end
        if (resp_valid_q && resp_ready) begin
            op_cnt_d = op_cnt_q + 1'b1;
        end
    end

    // Control registers with asynchronous reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr_q     <= '0;
            s1_vld_q     <= 1'b0;
            resp_valid_q <= 1'b0;
            resp_id_q    <= '0;
            resp_p_q     <= '0;
            op_cnt_q     <= '0;
        end else begin
            rr_ptr_q     <= rr_ptr_d;
            s1_vld_q     <= s1_vld_d;
            resp_valid_q <= resp_valid_d;
            resp_id_q    <= resp_id_d;
            resp_p_q     <= resp_p_d;
            op_cnt_q     <= op_cnt_d;
        end
    end

    // Issue-stage payload registers.
    always_ff @(posedge clk) begin
        s1_id_q <= s1_id_d;
        s1_x_q  <= s1_x_d;
        s1_y_q  <= s1_y_d;
    end

    assign resp_valid = resp_valid_q;
    assign resp_id    = resp_id_q;
    assign resp_p     = resp_p_q;
    assign op_cnt     = op_cnt_q;
    assign busy       = s1_vld_q || resp_valid_q;

endmodule

// File: tb/tb_mul_share_arb.sv
// Testbench for mul_share_arb: scoreboard of granted ops against responses,
// a table of corner operand pairs, and directed multi-cycle sequences.
module tb_mul_share_arb;

    localparam int WIDTH = 8;
    localparam int NREQ  = 4;
    localparam int IDW   = 2;
    localparam int CNTW  = 16;

    logic                  clk = 1'b0;
    logic                  rst_n = 1'b0;
    logic [NREQ-1:0]       req_valid = '0;
    logic [NREQ-1:0]       req_ready;
    logic [NREQ*WIDTH-1:0] req_x = '0;
    logic [NREQ*WIDTH-1:0] req_y = '0;
    logic                  resp_valid;
    logic                  resp_ready = 1'b0;
    logic [IDW-1:0]        resp_id;
    logic [2*WIDTH-1:0]    resp_p;
    logic                  busy;
    logic [CNTW-1:0]       op_cnt;

    mul_share_arb #(.WIDTH(WIDTH), .NREQ(NREQ), .IDW(IDW), .CNTW(CNTW)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_x(req_x), .req_y(req_y),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_id(resp_id), .resp_p(resp_p),
        .busy(busy), .op_cnt(op_cnt)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [IDW-1:0] id;
        logic [15:0]    p;
    } sb_t;

    typedef struct {
        logic [7:0]  x;
        logic [7:0]  y;
        logic [15:0] p;
    } vec_t;

    sb_t         sbq[$];
    int          gnt_log[$];
    logic [15:0] exp_cur[NREQ];
    vec_t        tbl[16];
    int          n_checks = 0;
    int          n_errors = 0;
    int          hs = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle scoreboard: pop on response handshake, push on grant.
    task automatic sb_cycle();
        sb_t e;
        chk("ready_onehot0", 32'($onehot0(req_ready)), 32'd1);
        if (resp_valid && resp_ready) begin
            hs++;
            if (sbq.size() == 0) begin
                chk("resp_unexpected", 32'd1, 32'd0);
            end else begin
                e = sbq.pop_front();
                chk("resp_id", 32'(resp_id), 32'(e.id));
                chk("resp_p", 32'(resp_p), 32'(e.p));
            end
        end
        for (int i = 0; i < NREQ; i++) begin
            if (req_valid[i] && req_ready[i]) begin
                e.id = IDW'(i);
                e.p  = exp_cur[i];
                sbq.push_back(e);
                gnt_log.push_back(i);
            end
        end
    endtask

    task automatic half();
        @(negedge clk);
        sb_cycle();
    endtask

    task automatic adv();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ops();
        logic [7:0] xv, yv;
        for (int i = 0; i < NREQ; i++) begin
            xv = 8'($urandom_range(0, 255));
            yv = 8'($urandom_range(0, 255));
            req_x[i*WIDTH +: WIDTH] = xv;
            req_y[i*WIDTH +: WIDTH] = yv;
            exp_cur[i] = {8'd0, xv} * {8'd0, yv};
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req_valid = '0;
        sbq.delete();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic drain();
        req_valid = '0;
        resp_ready = 1'b1;
        repeat (4) begin
            half();
            adv();
        end
        chk("drain_empty", 32'(sbq.size()), 32'd0);
    endtask

    initial begin
        logic [IDW-1:0] hold_id;
        logic [15:0]    hold_p;
        int             prev;
        int             budget;

        tbl[0]  = '{8'h00, 8'h00, 16'h0000};
        tbl[1]  = '{8'h00, 8'h01, 16'h0000};
        tbl[2]  = '{8'h00, 8'h80, 16'h0000};
        tbl[3]  = '{8'h00, 8'hFF, 16'h0000};
        tbl[4]  = '{8'h01, 8'h00, 16'h0000};
        tbl[5]  = '{8'h01, 8'h01, 16'h0001};
        tbl[6]  = '{8'h01, 8'h80, 16'h0080};
        tbl[7]  = '{8'h01, 8'hFF, 16'h00FF};
        tbl[8]  = '{8'h80, 8'h00, 16'h0000};
        tbl[9]  = '{8'h80, 8'h01, 16'h0080};
        tbl[10] = '{8'h80, 8'h80, 16'h4000};
        tbl[11] = '{8'h80, 8'hFF, 16'h7F80};
        tbl[12] = '{8'hFF, 8'h00, 16'h0000};
        tbl[13] = '{8'hFF, 8'h01, 16'h00FF};
        tbl[14] = '{8'hFF, 8'h80, 16'h7F80};
        tbl[15] = '{8'hFF, 8'hFF, 16'hFE01};
        for (int i = 0; i < NREQ; i++) exp_cur[i] = '0;

        // Reset state while reset is held, with requests pending
        req_valid = '1;
        #2;
        chk("rst_req_ready", 32'(req_ready), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_resp_valid", 32'(resp_valid), 32'd0);
        chk("rst_resp_id", 32'(resp_id), 32'd0);
        chk("rst_resp_p", 32'(resp_p), 32'd0);
        chk("rst_op_cnt", 32'(op_cnt), 32'd0);
        do_reset();

        // Single op from requester 2
        resp_ready = 1'b1;
        req_x[2*WIDTH +: WIDTH] = 8'd13;
        req_y[2*WIDTH +: WIDTH] = 8'd11;
        exp_cur[2] = 16'd143;
        req_valid = 4'b0100;
        half();
        chk("t1_req_ready", 32'(req_ready), 32'b0100);
        adv();
        req_valid = '0;
        half();
        chk("t1_resp_not_yet", 32'(resp_valid), 32'd0);
        chk("t1_busy", 32'(busy), 32'd1);
        adv();
        half();
        chk("t1_resp_valid", 32'(resp_valid), 32'd1);
        chk("t1_resp_id", 32'(resp_id), 32'd2);
        chk("t1_resp_p", 32'(resp_p), 32'd143);
        adv();
        half();
        chk("t1_op_cnt", 32'(op_cnt), 32'd1);
        chk("t1_idle", 32'(resp_valid), 32'd0);
        adv();

        // Round-robin with all requesters valid
        do_reset();
        gnt_log.delete();
        resp_ready = 1'b1;
        req_valid = '1;
        for (int c = 0; c < 12; c++) begin
            set_ops();
            half();
            adv();
        end
        drain();
        chk("t2_grants", 32'(gnt_log.size()), 32'd12);
        for (int k = 0; k < gnt_log.size(); k++) chk("t2_order", 32'(gnt_log[k]), 32'(k % NREQ));

        // Backpressure: resp_ready low during cycles 3..8
        do_reset();
        gnt_log.delete();
        req_valid = '1;
        hold_id = '0;
        hold_p = '0;
        for (int c = 0; c < 16; c++) begin
            resp_ready = !(c >= 3 && c <= 8);
            set_ops();
            half();
            if (c >= 3 && c <= 8) begin
                chk("t3_req_ready_full", 32'(req_ready), 32'd0);
                chk("t3_held", 32'(sbq.size()), 32'd2);
                chk("t3_resp_valid", 32'(resp_valid), 32'd1);
                if (c == 3) begin
                    hold_id = resp_id;
                    hold_p = resp_p;
                end else begin
                    chk("t3_stable_id", 32'(resp_id), 32'(hold_id));
                    chk("t3_stable_p", 32'(resp_p), 32'(hold_p));
                end
            end
            adv();
        end
        drain();
        for (int k = 0; k < gnt_log.size(); k++) chk("t3_order", 32'(gnt_log[k]), 32'(k % NREQ));

        // Corner operand table through requester 1
        do_reset();
        resp_ready = 1'b1;
        req_valid = 4'b0010;
        for (int k = 0; k < 16; k++) begin
            req_x[1*WIDTH +: WIDTH] = tbl[k].x;
            req_y[1*WIDTH +: WIDTH] = tbl[k].y;
            exp_cur[1] = tbl[k].p;
            half();
            chk("t4_req_ready", 32'(req_ready), 32'b0010);
            adv();
        end
        drain();

        // Reset with two ops in the pipe
        do_reset();
        resp_ready = 1'b0;
        req_valid = '1;
        set_ops();
        half();
        adv();
        half();
        adv();
        half();
        chk("t5_two_held", 32'(sbq.size()), 32'd2);
        adv();
        rst_n = 1'b0;
        #1;
        chk("t5_resp_valid", 32'(resp_valid), 32'd0);
        chk("t5_busy", 32'(busy), 32'd0);
        chk("t5_req_ready", 32'(req_ready), 32'd0);
        chk("t5_resp_id", 32'(resp_id), 32'd0);
        chk("t5_resp_p", 32'(resp_p), 32'd0);
        chk("t5_op_cnt", 32'(op_cnt), 32'd0);
        sbq.delete();
        req_valid = '0;
        resp_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int c = 0; c < 4; c++) begin
            half();
            chk("t5_no_stale", 32'(resp_valid), 32'd0);
            adv();
        end
        req_valid = '1;
        set_ops();
        half();
        chk("t5_rr_ptr0", 32'(req_ready), 32'b0001);
        adv();
        drain();

        // op_cnt wrap after 2**16 handshakes
        do_reset();
        resp_ready = 1'b1;
        req_x[0 +: WIDTH] = 8'd3;
        req_y[0 +: WIDTH] = 8'd5;
        exp_cur[0] = 16'd15;
        req_valid = 4'b0001;
        hs = 0;
        budget = 0;
        prev = 0;
        while (prev < 65536 && budget < 70000) begin
            prev = hs;
            half();
            if (prev == 65535) chk("t6_op_cnt_max", 32'(op_cnt), 32'hFFFF);
            if (prev == 65536) chk("t6_op_cnt_wrap", 32'(op_cnt), 32'd0);
            adv();
            budget++;
        end
        chk("t6_budget", 32'(budget < 70000), 32'd1);
        drain();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
